// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - memory-mapped bus controller: RAM, output registers, synchronised input ports
// Optional MMIO_IRQ_EN adds a change-flag mask register and a registered irq output.
module mmio_bus_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 9,
    parameter int                RAM_AW   = 8,
    parameter int                N_OUT    = 2,
    parameter int                N_IN     = 2,
    parameter logic [ADDR_W-1:0] OUT_BASE = 'h100,
    parameter logic [ADDR_W-1:0] IN_BASE  = 'h140,
    parameter int                RAM_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mem_cmd,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_ready,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [DATA_W-1:0]       ram_din,
    input  logic [DATA_W-1:0]       ram_dout,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic [N_OUT*DATA_W-1:0] out_port
`ifdef MMIO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam logic [ADDR_W-1:0] FLAG_ADDR = IN_BASE + ADDR_W'(N_IN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] out_reg   [N_OUT];
    logic [DATA_W-1:0] sync1     [N_IN];
    logic [DATA_W-1:0] sync2     [N_IN];
    logic [DATA_W-1:0] sync_prev [N_IN];
    logic [N_IN-1:0]   flags;
    logic [N_IN-1:0]   flag_set;
    logic              flag_clr;

    logic              is_ram;
    logic              hit_flag;
    logic [N_OUT-1:0]  out_sel;
    logic [N_IN-1:0]   in_sel;
    logic              wr_go;
    logic              rd_go;
    logic [DATA_W-1:0] rd_val;

`ifdef MMIO_IRQ_EN
    localparam logic [ADDR_W-1:0] MASK_ADDR = IN_BASE + ADDR_W'(N_IN + 1);
    logic [N_IN-1:0] mask;
    logic            hit_mask;
    assign hit_mask = !is_ram && (mem_addr == MASK_ADDR);
`endif

    assign is_ram   = !mem_addr[ADDR_W-1];
    assign hit_flag = !is_ram && (mem_addr == FLAG_ADDR);
    assign wr_go    = (state == S_IDLE) && (mem_cmd == 2'b10);
    assign rd_go    = (state == S_IDLE) && (mem_cmd == 2'b01);

    // RAM sees the CPU address and data directly; only the strobe is gated by the FSM.
    assign ram_addr = mem_addr[RAM_AW-1:0];
    assign ram_din  = wdata;
    assign ram_we   = wr_go && is_ram;
    assign flag_clr = rd_go && hit_flag;

    always_comb begin
        for (int i = 0; i < N_OUT; i++)
            out_sel[i] = !is_ram && (mem_addr == OUT_BASE + ADDR_W'(i));
        for (int i = 0; i < N_IN; i++) begin
            in_sel[i]   = !is_ram && (mem_addr == IN_BASE + ADDR_W'(i));
            flag_set[i] = (sync2[i] != sync_prev[i]);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_OUT; i++)
            if (out_sel[i]) rd_val = out_reg[i];
        for (int i = 0; i < N_IN; i++)
            if (in_sel[i]) rd_val = sync2[i];
        if (hit_flag) rd_val = DATA_W'(flags);
`ifdef MMIO_IRQ_EN
        if (hit_mask) rd_val = DATA_W'(mask);
`endif
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_out
            assign out_port[g*DATA_W +: DATA_W] = out_reg[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            for (int i = 0; i < N_OUT; i++) out_reg[i] <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_go) begin
                        for (int i = 0; i < N_OUT; i++)
                            if (out_sel[i]) out_reg[i] <= wdata;
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                    end else if (rd_go) begin
                        if (is_ram) begin
                            cnt   <= 2'(RAM_LAT - 1);
                            state <= S_WAIT;
                        end else begin
                            rdata     <= rd_val;
                            state     <= S_RESP;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        rdata     <= ram_dout;
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A change landing on the same edge as a flag read survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
            for (int i = 0; i < N_IN; i++) begin
                sync1[i]     <= '0;
                sync2[i]     <= '0;
                sync_prev[i] <= '0;
            end
        end else begin
            flags <= (flags & ~{N_IN{flag_clr}}) | flag_set;
            for (int i = 0; i < N_IN; i++) begin
                sync1[i]     <= in_port[i*DATA_W +: DATA_W];
                sync2[i]     <= sync1[i];
                sync_prev[i] <= sync2[i];
            end
        end
    end

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_go && hit_mask) mask <= wdata[N_IN-1:0];
            irq <= |(flags & mask);
        end
    end
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb/tb_mmio_bus_ctrl.sv - self-checking bench for mmio_bus_ctrl with a transaction-level model
module tb_mmio_bus_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        mem_ready;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [31:0] in_port;
    logic [31:0] out_port;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    mmio_bus_ctrl #(.RAM_LAT(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .mem_cmd(mem_cmd),
        .mem_addr(mem_addr),
        .wdata(wdata),
        .rdata(rdata),
        .mem_ready(mem_ready),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_din(ram_din),
        .ram_dout(ram_dout),
        .in_port(in_port),
        .out_port(out_port)
`ifdef MMIO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM with LAT cycles of read latency.
    logic [15:0] ram_mem  [256];
    logic [15:0] ram_pipe [LAT];
    assign ram_dout = ram_pipe[LAT-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_pipe[0] <= ram_mem[ram_addr];
        for (int k = LAT - 1; k > 0; k--) ram_pipe[k] <= ram_pipe[k-1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {int port; int e;} ev_t;
    ev_t         ev_q[$];
    int          last_clr;
    logic [15:0] m_out  [2];
    logic [15:0] m_ram  [256];
    logic [15:0] m_cur  [2];
    logic [15:0] m_prev [2];
    int          m_chg  [2];
    logic [15:0] m_mask;

    logic        checking = 1'b0;
    logic        busy = 1'b0;
    int          req_cyc;
    int          exp_lat;
    logic [1:0]  req_cmd;
    logic [8:0]  req_addr;
    logic [15:0] req_data;
    logic [15:0] exp_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Flag value seen by a read captured at edge e: any change event since the last clear.
    function automatic logic [15:0] m_flags(input int e);
        logic [15:0] f;
        f = '0;
        foreach (ev_q[k])
            if (ev_q[k].e >= last_clr && ev_q[k].e < e) f[ev_q[k].port] = 1'b1;
        return f;
    endfunction

    // An input change made after edge k is readable by a capture at edge k+3 or later.
    function automatic logic [15:0] m_in(input int i, input int e);
        return (m_chg[i] + 3 <= e) ? m_cur[i] : m_prev[i];
    endfunction

    function automatic logic [15:0] m_read(input logic [8:0] a, input int e);
        if (!a[8]) return m_ram[a[7:0]];
        if (a == 9'h100 || a == 9'h101) return m_out[a[0]];
        if (a == 9'h140 || a == 9'h141) return m_in(a[0], e);
        if (a == 9'h142) return m_flags(e);
`ifdef MMIO_IRQ_EN
        if (a == 9'h143) return m_mask;
`endif
        return 16'h0000;
    endfunction

    task automatic model_reset(input int k);
        ev_q.delete();
        last_clr = k;
        m_out[0] = '0;
        m_out[1] = '0;
        m_mask   = '0;
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = '0;
            m_chg[i]  = k;
            if (m_cur[i] != 16'h0000) ev_q.push_back('{port: i, e: k + 3});
        end
    endtask

    task automatic set_in(input int i, input logic [15:0] v);
        m_prev[i] = m_cur[i];
        if (v != m_cur[i]) ev_q.push_back('{port: i, e: cyc + 3});
        m_cur[i] = v;
        m_chg[i] = cyc;
        in_port[i*16 +: 16] = v;
    endtask

    task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                          output logic [15:0] got);
        int n;
        @(posedge clk); #1;
        mem_cmd  = c;
        mem_addr = a;
        wdata    = d;
        req_cyc  = cyc;
        req_cmd  = c;
        req_addr = a;
        req_data = d;
        exp_lat  = (c == 2'b01 && !a[8]) ? 1 + LAT : 1;
        if (c == 2'b01) begin
            exp_rdata = m_read(a, cyc + 1);
            if (a == 9'h142) last_clr = cyc + 1;
        end
        busy = 1'b1;
        n = 0;
        while (!mem_ready && n < 12) begin
            @(negedge clk);
            n++;
        end
        got = rdata;
        chk("handshake_done", {31'd0, mem_ready}, 32'd1);
        @(posedge clk); #1;
        if (c == 2'b10) begin
            if (!a[8]) m_ram[a[7:0]] = d;
            else if (a == 9'h100 || a == 9'h101) m_out[a[0]] = d;
`ifdef MMIO_IRQ_EN
            else if (a == 9'h143) m_mask = {14'd0, d[1:0]};
`endif
        end
        mem_cmd = 2'b00;
        busy    = 1'b0;
    endtask

    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_we;
        logic [15:0] eo;
        if (checking) begin
            exp_rdy = busy && (cyc - req_cyc == exp_lat);
            exp_we  = busy && (cyc == req_cyc) && (req_cmd == 2'b10) && !req_addr[8];
            chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_rdy});
            chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
            if (exp_rdy && req_cmd == 2'b01) chk("rdata", {16'd0, rdata}, {16'd0, exp_rdata});
            if (busy) begin
                chk("ram_addr", {24'd0, ram_addr}, {24'd0, req_addr[7:0]});
                chk("ram_din", {16'd0, ram_din}, {16'd0, req_data});
            end
            for (int i = 0; i < 2; i++) begin
                eo = m_out[i];
                if (busy && req_cmd == 2'b10 && req_addr == 9'h100 + i && cyc > req_cyc) eo = req_data;
                chk("out_port", {16'd0, out_port[i*16 +: 16]}, {16'd0, eo});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] got;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            m_ram[i]   = '0;
        end
        for (int k = 0; k < LAT; k++) ram_pipe[k] = '0;
        m_cur[0] = '0;
        m_cur[1] = '0;
        reset    = 1'b0;
        mem_cmd  = 2'b00;
        mem_addr = '0;
        wdata    = '0;
        in_port  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        chk("reset_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_out_port", out_port, 32'd0);
        chk("reset_ram_we", {31'd0, ram_we}, 32'd0);
        reset = 1'b1;
        model_reset(cyc);
        checking = 1'b1;

        // Output register write and readback.
        access(2'b10, 9'h100, 16'h00A5, got);
        chk("out0_value", {16'd0, out_port[15:0]}, 32'h00A5);
        access(2'b01, 9'h100, 16'h0000, got);
        chk("read_out0", {16'd0, got}, 32'h00A5);

        // RAM write and read, including both ends of the RAM window.
        access(2'b10, 9'h010, 16'hBEEF, got);
        access(2'b01, 9'h010, 16'h0000, got);
        chk("read_ram_010", {16'd0, got}, 32'hBEEF);
        access(2'b10, 9'h0FF, 16'h5A5A, got);
        access(2'b10, 9'h000, 16'h1357, got);
        access(2'b01, 9'h0FF, 16'h0000, got);
        chk("read_ram_0ff", {16'd0, got}, 32'h5A5A);
        access(2'b01, 9'h000, 16'h0000, got);
        chk("read_ram_000", {16'd0, got}, 32'h1357);

        // Input synchroniser depth and read-to-clear flags.
        set_in(1, 16'h0033);
        access(2'b01, 9'h141, 16'h0000, got);
        chk("in1_second_edge", {16'd0, got}, 32'h0000);
        access(2'b01, 9'h141, 16'h0000, got);
        chk("in1_settled", {16'd0, got}, 32'h0033);
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_read", {16'd0, got}, 32'h0002);
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_cleared", {16'd0, got}, 32'h0000);

        // A change arriving on the clearing edge keeps its flag.
        set_in(0, 16'h0001);
        repeat (5) @(posedge clk);
        #1;
        set_in(0, 16'h0000);
        @(posedge clk); #1;
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_before_clear", {16'd0, got}, 32'h0001);
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_set_beats_clear", {16'd0, got}, 32'h0001);
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_final_clear", {16'd0, got}, 32'h0000);

        // Unmapped and read-only addresses.
        access(2'b01, 9'h1F0, 16'h0000, got);
        chk("unmapped_read", {16'd0, got}, 32'h0000);
        access(2'b10, 9'h1F0, 16'hFFFF, got);
        access(2'b10, 9'h140, 16'hFFFF, got);
        access(2'b01, 9'h140, 16'h0000, got);
        chk("in0_not_writable", {16'd0, got}, 32'h0000);
`ifndef MMIO_IRQ_EN
        access(2'b01, 9'h143, 16'h0000, got);
        chk("mask_addr_unmapped", {16'd0, got}, 32'h0000);
`endif

        // Reset in the middle of a RAM read.
        access(2'b10, 9'h101, 16'h1234, got);
        chk("out1_value", {16'd0, out_port[31:16]}, 32'h1234);
        @(posedge clk); #1;
        mem_cmd  = 2'b01;
        mem_addr = 9'h010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset   = 1'b0;
        mem_cmd = 2'b00;
        m_out[0] = '0;
        m_out[1] = '0;
        #1;
        chk("midreset_out_port", out_port, 32'd0);
        chk("midreset_ready", {31'd0, mem_ready}, 32'd0);
        chk("midreset_rdata", {16'd0, rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset(cyc);
        repeat (8) @(negedge clk);
        access(2'b01, 9'h101, 16'h0000, got);
        chk("out1_after_reset", {16'd0, got}, 32'h0000);
        access(2'b01, 9'h142, 16'h0000, got);
        chk("flag_resync_after_reset", {16'd0, got}, 32'h0002);
        access(2'b10, 9'h100, 16'h0077, got);

`ifdef MMIO_IRQ_EN
        access(2'b10, 9'h143, 16'h0001, got);
        access(2'b01, 9'h143, 16'h0000, got);
        chk("mask_readback", {16'd0, got}, 32'h0001);
        access(2'b01, 9'h142, 16'h0000, got);
        begin
            int k;
            k = cyc;
            set_in(0, 16'h0005);
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                chk("irq", {31'd0, irq}, {31'd0, (cyc >= k + 4)});
            end
        end
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised memory-mapped bus controller between the CPU memory interface (mem_cmd / mem_addr / data) and the synchronous data RAM, plus banks of output and input registers. It generalises the fixed single-LED / single-switch decode to N_OUT output and N_IN input ports at configurable bases. It adds a ready handshake that absorbs configurable RAM read latency. Input ports get synchronisers and sticky change flags.

Parameters:
DATA_W, 16, data bus width
ADDR_W, 9, CPU address width; addr[ADDR_W-1]==0 selects RAM
RAM_AW, 8, RAM address width (ram_addr = mem_addr[RAM_AW-1:0])
N_OUT, 2, number of output registers (1..8)
N_IN, 2, number of input ports (1..DATA_W)
OUT_BASE, 9'h100, address of output register 0
IN_BASE, 9'h140, address of input port 0
RAM_LAT, 1, RAM read latency in cycles (1..4)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
mem_cmd  in  2  00 MNONE, 01 MREAD, 10 MWRITE; 11 treated as MNONE
mem_addr  in  ADDR_W  access address, held by CPU until mem_ready
wdata  in  DATA_W  write data, held with mem_cmd
rdata  out  DATA_W  registered read data, valid when mem_ready=1
mem_ready  out  1  one-cycle completion pulse
ram_addr  out  RAM_AW  RAM address
ram_we  out  1  RAM write enable
ram_din  out  DATA_W  RAM write data (= wdata)
ram_dout  in  DATA_W  RAM read data, valid RAM_LAT cycles after address
in_port  in  N_IN*DATA_W  asynchronous input ports, port i at [i*DATA_W +: DATA_W]
out_port  out  N_OUT*DATA_W  output registers, same packing

Behaviour:
- Address decode:
  - RAM: addr[ADDR_W-1]==0.
  - OUT: OUT_BASE..OUT_BASE+N_OUT-1, read/write.
  - IN: IN_BASE..IN_BASE+N_IN-1, read-only.
  - FLAG: IN_BASE+N_IN, read-to-clear.
  - Anything else is unmapped: reads return 0, writes are ignored; the handshake still completes.
- FSM states: IDLE, WAIT, RESP.
- IDLE, MNONE: stay in IDLE.
- IDLE, MWRITE:
  - ram_we=1 combinationally this cycle if RAM region.
  - OUT register written at this edge if OUT region.
  - Writes to IN or FLAG are ignored.
  - Go to RESP.
- IDLE, MREAD non-RAM: rdata <= selected value at this edge; go to RESP.
  - OUT region returns the register readback.
  - IN region returns the synchronised value.
  - FLAG returns zero-extended flags and clears them.
- IDLE, MREAD RAM: load cnt=RAM_LAT-1; go to WAIT.
- WAIT:
  - cnt!=0: decrement cnt.
  - cnt==0: rdata <= ram_dout; go to RESP.
- RESP: mem_ready=1 for exactly one cycle; go to IDLE. A command still present in that IDLE cycle starts a new access.
- Latency (request cycle = 0):
  - Write, or non-RAM read: mem_ready in cycle 1.
  - RAM read: mem_ready in cycle 1+RAM_LAT.
- ram_we is never asserted outside IDLE, so each write is applied exactly once.
- Input ports: 2-flop synchroniser per port. sync_prev holds the previous synchronised value.
- Change flags:
  - flag[i] sets when sync[i] != sync_prev[i].
  - On a FLAG read, flags clear at the capture edge.
  - Set beats clear on the same edge.
- Reset (asynchronous, any state, including mid-access):
  - State IDLE; mem_ready=0; rdata=0.
  - out_port all 0; synchronisers, sync_prev and flags all 0.
  - Any pending access is dropped; no partial write.

Optional Feature:
MMIO_IRQ_EN
- Defined:
  - Adds output irq (1 bit).
  - Adds RW mask register (N_IN bits, reset 0) at IN_BASE+N_IN+1.
  - irq is registered: irq <= |(flags & mask) each cycle; reset 0.
- Undefined: no irq port; that address is unmapped.

Test Plan:
- Reset, then MWRITE 9'h100 wdata 16'h00A5 -> out_port[0]=16'h00A5 after cycle 0; mem_ready pulses in cycle 1; ram_we=0; MREAD 9'h100 returns 16'h00A5.
- RAM_LAT=3: MWRITE 9'h010 16'hBEEF (ram_we=1 only in cycle 0) -> MREAD 9'h010 gives mem_ready in cycle 4 with rdata=16'hBEEF.
- in_port[1] changes 0->16'h0033 -> MREAD 9'h141 returns 16'h0033 from the 3rd edge on; MREAD 9'h142 returns 16'h0002; a second read returns 16'h0000.
- in_port[0] toggles on the same edge that a FLAG read clears -> flag[0] stays set; the next FLAG read returns 16'h0001.
- MREAD 9'h1F0 (unmapped) -> rdata=0, mem_ready in cycle 1; MWRITE 9'h1F0 -> no out_port or RAM change.
- Assert reset during WAIT after writing out_port[1]=16'h1234 -> mem_ready never pulses; out_port=0; FSM IDLE. With MMIO_IRQ_EN: mask=2'b01 plus in_port[0] change -> irq=1 one cycle after flag sets.
